smem_arbiter: RTL and testbench
===============================

Name: smem_arbiter

Overview:
- Sequential arbiter for the shared 256x8 single-port S-memory.
- Three requesters share it: index 0 = init FSM, 1 = swap/KSA FSM, 2 = decode FSM.
- Replaces the static addr_data_sel mux with a req/gnt handshake, read-valid tracking and an optional hold limit.
- The master FSM still sequences phases. This block guarantees that exactly one owner drives the RAM port and that the owner's last read is delivered.

Parameters:
- AW, 8, S-memory address width.
- DW, 8, S-memory data width.
- HOLD_LIMIT, 0, maximum consecutive granted cycles while another requester is waiting; 0 = unlimited.

Ports:
- clock  in  1  system clock; all state is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  3  per-requester access request; bit i = requester i.
- addr_in  in  3*AW  packed addresses; requester i uses bits [i*AW +: AW].
- wdata_in  in  3*DW  packed write data, same packing as addr_in.
- wren_in  in  3  per-requester write enable.
- gnt  out  3  registered one-hot grant.
- rvalid  out  3  one-hot pulse: rdata holds requester i's read result.
- rdata  out  DW  read data; equals mem_q.
- mem_address  out  AW  to S-memory address.
- mem_data  out  DW  to S-memory data.
- mem_wren  out  1  to S-memory wren.
- mem_q  in  DW  from S-memory q; 1-cycle read latency.
- busy  out  1  high while in GRANT or HANDOFF.
- owner  out  2  index of the current owner; 2'd3 when none.

Behaviour:
- Reset (asynchronous) forces:
  - state IDLE, gnt=0, rvalid=0, mem_wren=0, busy=0, owner=3;
  - hold counter 0, read-pending flag 0, round-robin pointer 0.
- A reset asserted mid-transfer aborts the transfer. No write may issue in the cycle reset is high.
- States:
  - IDLE:
    - When req!=0, pick a winner.
    - Register gnt[w]=1 and owner=w; next state GRANT. The grant is visible one cycle after req.
  - GRANT:
    - The memory port is driven combinationally from the owner: mem_address=addr_in[owner], mem_data=wdata_in[owner], mem_wren=wren_in[owner].
    - Non-owners' wren, addr and data are ignored.
    - If req[owner] falls, go to HANDOFF; gnt drops in the same registered update.
    - If HOLD_LIMIT>0, the hold counter reaches HOLD_LIMIT and any other req is high, preempt: gnt drops and go to HANDOFF. The owner's req stays pending and it re-arbitrates later.
  - HANDOFF:
    - Exactly one cycle. mem_wren forced 0, gnt=0, memory port driven from the last owner.
    - Lets the final read's q land. Next state IDLE.
- Read tracking: a granted cycle with wren_in[owner]=0 and req[owner]=1 at cycle t sets rvalid[owner]=1 at t+1, with rdata=mem_q. rvalid is a 1-cycle pulse per read.
- Hold counter:
  - Clears on entry to GRANT; increments each GRANT cycle; saturates at 2^16-1.
  - Ignored when HOLD_LIMIT=0.
- Simultaneous events:
  - A req falling in the same cycle a preemption fires is treated as a normal release.
  - A requester that raises req during HANDOFF is considered in the next IDLE.
- A winner is selected only in IDLE; there is no back-to-back grant without HANDOFF.
- Every granted write completes in its cycle; the RAM performs the write at that edge.

Optional Feature:
- Macro: SMEM_ARB_ROUND_ROBIN_EN.
- Defined:
  - Round-robin: search starts at the index after the last owner, wrapping 2->0.
  - The pointer updates on each grant and resets to 0.
- Undefined: fixed priority, index 0 highest, then 1, then 2. No pointer register is synthesized.

Test Plan:
- Reset, then req=3'b001 with addr 8'h05, wren=1, wdata 8'h05 → gnt=3'b001 one cycle later; mem_wren=1 and mem_address=8'h05 while granted; owner=0.
- Requester 1 granted, reads address 8'h10 (RAM holds 8'hA7) → rvalid=3'b010 next cycle with rdata=8'hA7. Drop req → exactly one HANDOFF cycle with gnt=0 and mem_wren=0, then IDLE.
- req=3'b111 with macro undefined → grants in order 0,1,2 as each releases. With macro defined and last owner 1 → next grant goes to 2, then 0.
- HOLD_LIMIT=4, owner 2 holds req, requester 0 raises req → gnt[2] drops after 4 granted cycles, HANDOFF, then gnt=3'b001.
- Requester 1 drives wren_in[1]=1 while 0 owns → mem_wren follows wren_in[0] only; memory contents at requester 1's address are unchanged.
- Assert reset mid-GRANT with wren=1 → gnt, mem_wren and rvalid go 0 immediately (asynchronous); after release, state IDLE and owner=3.

Source files
------------

// File: rtl/smem_arbiter.sv
// smem_arbiter: req/gnt arbiter for the shared single-port S-memory.
// Define SMEM_ARB_ROUND_ROBIN_EN for round-robin; default is fixed priority.

module smem_arbiter #(
  parameter int unsigned AW         = 8,
  parameter int unsigned DW         = 8,
  parameter int unsigned HOLD_LIMIT = 0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [2:0]      req,
  input  logic [3*AW-1:0] addr_in,
  input  logic [3*DW-1:0] wdata_in,
  input  logic [2:0]      wren_in,
  output logic [2:0]      gnt,
  output logic [2:0]      rvalid,
  output logic [DW-1:0]   rdata,
  output logic [AW-1:0]   mem_address,
  output logic [DW-1:0]   mem_data,
  output logic            mem_wren,
  input  logic [DW-1:0]   mem_q,
  output logic            busy,
  output logic [1:0]      owner
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_HANDOFF = 2'd2
  } state_t;

  localparam logic [1:0] NO_OWNER = 2'd3;

  function automatic logic [2:0] onehot(
    input logic [1:0] i
  );
    logic [2:0] m;
    unique case (i)
      2'd0:    m = 3'b001;
      2'd1:    m = 3'b010;
      2'd2:    m = 3'b100;
      default: m = 3'b000;
    endcase
    return m;
  endfunction

  // First requester found in the order a, b, c.
  function automatic logic [1:0] first_of(
    input logic [2:0] r,
    input logic [1:0] a,
    input logic [1:0] b,
    input logic [1:0] c
  );
    logic [1:0] w;
    w = c;
    if (r[b]) w = b;
    if (r[a]) w = a;
    return w;
  endfunction

  state_t        state_q, state_d;
  logic [2:0]    gnt_q, gnt_d;
  logic [1:0]    owner_q, owner_d;
  logic [15:0]   hold_q, hold_d;
  logic [2:0]    rd_pend_q, rd_pend_d;

  logic          own_req;
  logic          own_wren;
  logic [AW-1:0] own_addr;
  logic [DW-1:0] own_data;
  logic [2:0]    own_mask;
  logic          others_req;
  logic [1:0]    win;
  logic [16:0]   hold_inc;
  logic [15:0]   hold_next;
  logic          limit_hit;

  // Route the current owner's request bundle.
  always_comb begin
    own_req  = 1'b0;
    own_wren = 1'b0;
    own_addr = '0;
    own_data = '0;
    unique case (owner_q)
      2'd0: begin
        own_req  = req[0];
        own_wren = wren_in[0];
        own_addr = addr_in[0*AW +: AW];
        own_data = wdata_in[0*DW +: DW];
      end
      2'd1: begin
        own_req  = req[1];
        own_wren = wren_in[1];
        own_addr = addr_in[1*AW +: AW];
        own_data = wdata_in[1*DW +: DW];
      end
      2'd2: begin
        own_req  = req[2];
        own_wren = wren_in[2];
        own_addr = addr_in[2*AW +: AW];
        own_data = wdata_in[2*DW +: DW];
      end
      default: ;
    endcase
  end

  assign own_mask   = onehot(owner_q);
  assign others_req = |(req & ~own_mask);

`ifdef SMEM_ARB_ROUND_ROBIN_EN
  logic [1:0] rr_ptr_q, rr_ptr_d;

  // Winner search starts just after the last owner.
  always_comb begin
    win = 2'd0;
    unique case (rr_ptr_q)
      2'd1:    win = first_of(req, 2'd1, 2'd2, 2'd0);
      2'd2:    win = first_of(req, 2'd2, 2'd0, 2'd1);
      default: win = first_of(req, 2'd0, 2'd1, 2'd2);
    endcase
  end

  // Advance the pointer past each new owner.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (state_q == S_IDLE && |req) begin
      rr_ptr_d = (win == 2'd2) ? 2'd0 : win + 2'd1;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) rr_ptr_q <= 2'd0;
    else       rr_ptr_q <= rr_ptr_d;
  end
`else
  // Fixed priority: requester 0 highest.
  always_comb begin
    win = first_of(req, 2'd0, 2'd1, 2'd2);
  end
`endif

  assign hold_inc  = {1'b0, hold_q} + 17'd1;
  assign hold_next = (&hold_q) ? hold_q : hold_inc[15:0];
  assign limit_hit = (HOLD_LIMIT != 0) &&
                     (32'(hold_inc) >= HOLD_LIMIT);

  // Next-state, grant, hold and read-tracking logic.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    hold_d    = hold_q;
    rd_pend_d = 3'b000;
    unique case (state_q)
      S_IDLE: begin
        gnt_d   = 3'b000;
        owner_d = NO_OWNER;
        if (|req) begin
          state_d = S_GRANT;
          gnt_d   = onehot(win);
          owner_d = win;
          hold_d  = 16'd0;
        end
      end
      S_GRANT: begin
        hold_d = hold_next;
        if (own_req && !own_wren) begin
          rd_pend_d = own_mask;
        end
        if (!own_req || (limit_hit && others_req)) begin
          state_d = S_HANDOFF;
          gnt_d   = 3'b000;
        end
      end
      S_HANDOFF: begin
        state_d = S_IDLE;
        gnt_d   = 3'b000;
        owner_d = NO_OWNER;
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = 3'b000;
        owner_d = NO_OWNER;
      end
    endcase
  end

  // State registers; reset aborts any transfer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      gnt_q     <= 3'b000;
      owner_q   <= NO_OWNER;
      hold_q    <= 16'd0;
      rd_pend_q <= 3'b000;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      hold_q    <= hold_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  assign gnt         = gnt_q;
  assign owner       = owner_q;
  assign busy        = (state_q != S_IDLE);
  assign rvalid      = rd_pend_q;
  assign rdata       = mem_q;
  assign mem_address = own_addr;
  assign mem_data    = own_data;
  assign mem_wren    = (state_q == S_GRANT) &&
                       own_wren && !reset;

endmodule

// File: tb/tb_smem_arbiter.sv
// tb_smem_arbiter: randomized bench for smem_arbiter
// against a transaction-level model and a shadow memory.

module tb_smem_arbiter;

  localparam int HL = 4;

  logic        clock;
  logic        reset;
  logic [2:0]  req;
  logic [23:0] addr_in;
  logic [23:0] wdata_in;
  logic [2:0]  wren_in;
  logic [2:0]  gnt;
  logic [2:0]  rvalid;
  logic [7:0]  rdata;
  logic [7:0]  mem_address;
  logic [7:0]  mem_data;
  logic        mem_wren;
  logic [7:0]  mem_q;
  logic        busy;
  logic [1:0]  owner;
  logic        ram_init;

  logic [7:0]  ram [256];
  logic [7:0]  shadow [256];

  int n_chk = 0;
  int n_fail = 0;

  // model: 0 idle, 1 granted, 2 handoff
  int         m_phase;
  int         m_own;
  int         m_held;
  int         m_last;
  logic [2:0] m_rv;
  logic [7:0] m_rd;

  smem_arbiter #(.AW(8), .DW(8), .HOLD_LIMIT(HL)) dut (
    .clock(clock), .reset(reset), .req(req),
    .addr_in(addr_in), .wdata_in(wdata_in),
    .wren_in(wren_in), .gnt(gnt), .rvalid(rvalid),
    .rdata(rdata), .mem_address(mem_address),
    .mem_data(mem_data), .mem_wren(mem_wren),
    .mem_q(mem_q), .busy(busy), .owner(owner)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'(i) ^ 8'h5A;
      ram[16] <= 8'hA7;
    end else begin
      mem_q <= ram[mem_address];
      if (mem_wren) ram[mem_address] <= mem_data;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [7:0] a_of(input int i);
    return addr_in[i*8 +: 8];
  endfunction

  function automatic logic [7:0] w_of(input int i);
    return wdata_in[i*8 +: 8];
  endfunction

  function automatic int pick(input logic [2:0] r);
`ifdef SMEM_ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= 3; k++) begin
      if (r[(m_last + k) % 3]) return (m_last + k) % 3;
    end
`else
    for (int k = 0; k < 3; k++) if (r[k]) return k;
`endif
    return 0;
  endfunction

  task automatic set_req(input int i, input bit r,
                         input bit w,
                         input logic [7:0] a,
                         input logic [7:0] d);
    req[i] = r;
    wren_in[i] = w;
    addr_in[i*8 +: 8] = a;
    wdata_in[i*8 +: 8] = d;
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_rv = 3'b000;
    m_last = 2;
  endtask

  task automatic reset_now();
    reset = 1'b1;
    model_reset();
  endtask

  task automatic check_outputs();
    logic [2:0] eg;
    eg = (m_phase == 1) ? 3'(1 << m_own) : 3'b000;
    chk("gnt", gnt, eg);
    chk("owner", owner, (m_phase == 0) ? 3 : m_own);
    chk("busy", busy, m_phase != 0);
    chk("mem_wren", mem_wren,
        m_phase == 1 && wren_in[m_own]);
    if (m_phase != 0)
      chk("mem_address", mem_address, a_of(m_own));
    if (m_phase == 1)
      chk("mem_data", mem_data, w_of(m_own));
    chk("rvalid", rvalid, m_rv);
    if (m_rv != 0) chk("rdata", rdata, m_rd);
  endtask

  // evaluated at the clock edge with pre-edge inputs
  task automatic model_update();
    if (reset) begin
      model_reset();
    end else begin
      m_rv = 3'b000;
      if (m_phase == 1) begin
        if (req[m_own] && !wren_in[m_own]) begin
          m_rv = 3'(1 << m_own);
          m_rd = shadow[a_of(m_own)];
        end
        if (wren_in[m_own])
          shadow[a_of(m_own)] = w_of(m_own);
        m_held++;
        if (!req[m_own] ||
            (HL > 0 && m_held >= HL &&
             (req & ~3'(1 << m_own)) != 0))
          m_phase = 2;
      end else if (m_phase == 2) begin
        m_phase = 0;
      end else if (req != 0) begin
        m_own = pick(req);
        m_last = m_own;
        m_held = 0;
        m_phase = 1;
      end
    end
  endtask

  task automatic cyc();
    @(negedge clock);
    check_outputs();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic wait_gnt();
    int t;
    t = 0;
    while (gnt == 3'b000 && t < 20) begin
      cyc();
      t++;
    end
    chk("gnt_wait_in_budget", t < 20, 1'b1);
  endtask

  task automatic run_order(input logic [2:0] r,
                           input int cnt,
                           input int e0, input int e1,
                           input int e2);
    int o;
    for (int i = 0; i < 3; i++)
      set_req(i, r[i], 1'b0, 8'(8'h10 + i), 8'h00);
    for (int n = 0; n < cnt; n++) begin
      wait_gnt();
      o = int'(owner);
      chk($sformatf("order%0d", n), o,
          (n == 0) ? e0 : (n == 1) ? e1 : e2);
      cyc();
      if (o < 3) req[o] = 1'b0;
      cyc();
      cyc();
    end
  endtask

  initial begin
    int cnt;
    int mism;
    logic [7:0] pre;
    reset = 1'b1;
    ram_init = 1'b1;
    req = '0;
    addr_in = '0;
    wdata_in = '0;
    wren_in = '0;
    m_own = 0;
    m_held = 0;
    m_rd = 8'h00;
    model_reset();
    for (int i = 0; i < 256; i++) shadow[i] = 8'(i) ^ 8'h5A;
    shadow[16] = 8'hA7;
    cyc();
    cyc();
    ram_init = 1'b0;
    chk("rst_gnt", gnt, 3'b000);
    chk("rst_rvalid", rvalid, 3'b000);
    chk("rst_wren", mem_wren, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_owner", owner, 2'd3);
    reset = 1'b0;
    cyc();

    // single write by requester 0
    set_req(0, 1'b1, 1'b1, 8'h05, 8'h05);
    cyc();
    chk("t1_gnt", gnt, 3'b001);
    chk("t1_owner", owner, 2'd0);
    chk("t1_wren", mem_wren, 1'b1);
    chk("t1_addr", mem_address, 8'h05);
    cyc();
    set_req(0, 1'b0, 1'b0, 8'h05, 8'h05);
    cyc();
    cyc();
    chk("t1_ram", ram[8'h05], 8'h05);

    // read by requester 1, release, handoff
    set_req(1, 1'b1, 1'b0, 8'h10, 8'h00);
    cyc();
    chk("t2_gnt", gnt, 3'b010);
    cyc();
    chk("t2_rvalid", rvalid, 3'b010);
    chk("t2_rdata", rdata, 8'hA7);
    req[1] = 1'b0;
    cyc();
    chk("t2_ho_gnt", gnt, 3'b000);
    chk("t2_ho_wren", mem_wren, 1'b0);
    chk("t2_ho_busy", busy, 1'b1);
    cyc();
    chk("t2_idle_busy", busy, 1'b0);
    chk("t2_idle_owner", owner, 2'd3);

    // arbitration order
`ifdef SMEM_ARB_ROUND_ROBIN_EN
    run_order(3'b111, 3, 2, 0, 1);
    run_order(3'b010, 1, 1, 0, 0);
    run_order(3'b111, 3, 2, 0, 1);
`else
    run_order(3'b111, 3, 0, 1, 2);
    run_order(3'b010, 1, 1, 0, 0);
    run_order(3'b111, 3, 0, 1, 2);
`endif

    // hold limit preemption
    set_req(2, 1'b1, 1'b0, 8'h30, 8'h00);
    wait_gnt();
    chk("hold_gnt2", gnt, 3'b100);
    set_req(0, 1'b1, 1'b0, 8'h31, 8'h00);
    cnt = 0;
    while (gnt[2] && cnt < 20) begin
      cyc();
      cnt++;
    end
    chk("hold_cycles", cnt, HL);
    chk("hold_ho_busy", busy, 1'b1);
    cyc();
    cyc();
    chk("hold_next_gnt", gnt, 3'b001);
    req[0] = 1'b0;
    cyc();
    cyc();
    cyc();
    chk("hold_regrant", gnt, 3'b100);
    req[2] = 1'b0;
    cyc();
    cyc();

    // non-owner write is ignored
    set_req(0, 1'b1, 1'b0, 8'h40, 8'h00);
    set_req(1, 1'b0, 1'b1, 8'h41, 8'hEE);
    wait_gnt();
    chk("nonown_gnt", gnt, 3'b001);
    chk("nonown_wren", mem_wren, 1'b0);
    cyc();
    cyc();
    set_req(0, 1'b0, 1'b0, 8'h40, 8'h00);
    set_req(1, 1'b0, 1'b0, 8'h41, 8'h00);
    cyc();
    cyc();
    chk("nonown_mem", ram[8'h41], 8'h41 ^ 8'h5A);

    // asynchronous reset during a granted write
    set_req(2, 1'b1, 1'b1, 8'h33, 8'h99);
    wait_gnt();
    chk("arst_pre_wren", mem_wren, 1'b1);
    pre = ram[8'h33];
    #2;
    reset_now();
    #1;
    chk("arst_gnt", gnt, 3'b000);
    chk("arst_wren", mem_wren, 1'b0);
    chk("arst_rvalid", rvalid, 3'b000);
    chk("arst_owner", owner, 2'd3);
    chk("arst_busy", busy, 1'b0);
    set_req(2, 1'b0, 1'b0, 8'h33, 8'h00);
    cyc();
    reset = 1'b0;
    cyc();
    chk("arst_idle_owner", owner, 2'd3);
    chk("arst_mem", ram[8'h33], pre);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(4) == 0) req[i] = ~req[i];
        wren_in[i] = ($urandom_range(2) == 0);
        addr_in[i*8 +: 8] = 8'(8'h20 + $urandom_range(15));
        wdata_in[i*8 +: 8] = 8'($urandom);
      end
      if ($urandom_range(600) == 0) reset_now();
      cyc();
    end
    reset = 1'b0;
    req = '0;
    wren_in = '0;
    cyc();
    cyc();
    cyc();

    mism = 0;
    for (int i = 0; i < 256; i++)
      if (ram[i] !== shadow[i]) mism++;
    chk("mem_final", mism, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
